alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares the single registered ALU between two requesters: port 0 = execute stage, port 1 = branch-compare unit.
//  Per port: valid/ready request channel and valid/ready response channel.
//  Only one op is in flight at a time. The arbiter tracks the ALU's one-clock registered latency and steers the result back.
//  Derives a consistent zero flag, because the ALU updates its zero output only on SUB.
// PARAMETERS
//  XLEN      32  operand/result width
//  OPW       4   ALU control code width
// PORTS
//  clk             in   1     single clock, rising edge
//  rst             in   1     reset, asynchronous, active-high
//  reqN_valid      in   1     request N presents op (N = 0,1)
//  reqN_ready      out  1     request N accepted this cycle
//  reqN_a/reqN_b   in   XLEN  operands
//  reqN_op         in   OPW   ALU control code
//  respN_valid     out  1     response N holds a result
//  respN_ready     in   1     requester N consumes response
//  respN_result    out  XLEN  ALU result
//  respN_zero      out  1     result == 0
//  respN_err       out  1     op code not supported by ALU
//  alu_a/alu_b     out  XLEN  operands to ALU
//  alu_ctrl        out  OPW   control code to ALU
//  alu_result      in   XLEN  registered ALU result
//  alu_zero        in   1     ALU zero flag (valid only after SUB)
// BEHAVIOUR
//  FSM: IDLE -> ISSUE -> CAPT -> RESP -> IDLE. One op per 4 cycles minimum.
//  IDLE:
//   - reqN_ready = 1 only for the granted port, and only when it is valid. Combinational in IDLE; 0 in all other states.
//   - On accept edge: latch a, b, op and owner; go to ISSUE.
//  ISSUE: alu_a/alu_b/alu_ctrl driven from latched regs. ALU samples at the end of this cycle. Go to CAPT.
//  CAPT: alu_result valid. Capture into resp regs at edge; go to RESP.
//  RESP:
//   - respN_valid = 1 for owner only; data held stable until respN_ready.
//   - Edge with ready: go to IDLE. The new request is granted in the following IDLE cycle, so there is no same-cycle accept.
//  Latency: accept edge to respN_valid high = 2 clocks.
//  Zero flag:
//   - op == 4'b0110 (SUB): respN_zero = alu_zero.
//   - Otherwise: respN_zero = (alu_result == 0), computed locally.
//  Supported ops: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR, 0101 SRL, 0100 SLL, 0111 ASR1.
//   - Any other code is still issued (ALU returns 0).
//   - respN_err = 1, respN_zero = 1.
//  alu_ctrl/alu_a/alu_b hold the last issued values outside ISSUE, so the ALU recomputes harmlessly.
//  Arbitration (default): round-robin.
//   - Both valid in IDLE: grant the port not granted last.
//   - last_grant updates on accept only.
//  Reset values:
//   - state=IDLE; last_grant=1 (port 0 wins first tie).
//   - all ready/valid/err/zero = 0; resp results = 0; alu_a = alu_b = 0; alu_ctrl = 4'b0000.
//  Reset mid-op: in-flight op and pending response discarded, no response issued.
//   - ALU output after reset release is ignored until the next ISSUE.
//  Requester dropping valid before ready: no grant, no side effects (protocol violation not flagged).
//  Response backpressure: non-owner port may hold valid indefinitely; it is granted after the owner consumes its response.
// CONFIGURATION
//  ALU_ARB_FIXED_PRIO_EN:
//   - Defined: fixed priority. Port 0 always wins ties; port 1 may starve. last_grant is still maintained but unused.
//   - Undefined (default): round-robin as above.
// STRUCTURE
//  Shared package alu_pkg:
//   - ALU op localparams (ALU_AND..ALU_ASR1)
//   - function alu_op_supported(op)
//   - FSM state encoding typedef (IDLE/ISSUE/CAPT/RESP)
//  Sub-module rr_arb2: 2-way grant from valids + last_grant, with the fixed-priority variant under the macro.
//  The rest is inline: FSM, latch/capture regs, response muxing.
// TESTING
//  Single op: req0 ADD 5+7 -> req0_ready 1 cycle; resp0_valid 2 clocks later; result 12, zero 0, err 0.
//  Tie:
//   - After reset, both valid (req0 SUB 9-9, req1 OR 0|0) -> port 0 first: result 0, zero 1 via alu_zero.
//   - Then port 1: result 0, zero 1 via local compare.
//   - Third tie goes to port 0.
//  Backpressure: resp1_ready low 10 cycles -> resp1_result stable, req0_ready stays 0 throughout; req0 served after consume.
//  Illegal op: req1 op 4'b1010 -> resp1_result 0, err 1, zero 1.
//  Reset in CAPT:
//   - rst pulse -> resp*_valid never asserts for that op.
//   - Next req0 XOR 0xF0F0^0x0FF0 -> 0xFF00.
//  Macro: with ALU_ARB_FIXED_PRIO_EN, continuous valid on both -> port 0 granted every time, port 1 never.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: op codes, op legality check
// and FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_ASR1 = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  function automatic logic alu_op_supported(input logic [3:0] op);
    logic ok;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SUB, ALU_ASR1: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// One requester's request/response channel pair; the arbiter takes the slave
// side, the requester (execute stage or branch-compare unit) the master side.
interface alu_share_arbiter_if #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic [OPW-1:0]  req_op;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;
  logic            resp_zero;
  logic            resp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero, resp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero, resp_err
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way grant from request valids and the last granted port.
// Build with ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins ties).
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] gnt
);
`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign gnt[0] = valid[0];
  assign gnt[1] = valid[1] & ~valid[0];
`else
  // On a tie the port that did not win last time is granted.
  assign gnt[0] = valid[0] & (~valid[1] | last_grant);
  assign gnt[1] = valid[1] & (~valid[0] | ~last_grant);
`endif
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one registered ALU between two requesters, one op in flight at a time.
// Arbitration is round-robin unless ALU_ARB_FIXED_PRIO_EN is defined.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  alu_share_arbiter_if.slave p0,
  alu_share_arbiter_if.slave p1,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [OPW-1:0]  alu_ctrl,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero
);

  arb_state_t      state;
  logic            last_grant;
  logic            owner;
  logic [1:0]      gnt;
  logic [1:0]      resp_vld;
  logic [XLEN-1:0] res_q;
  logic            zero_q;
  logic            err_q;
  logic            consumed;
  logic            op_ok;

  rr_arb2 u_arb (
    .valid      ({p1.req_valid, p0.req_valid}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign p0.req_ready = (state == IDLE) & gnt[0] & ~rst;
  assign p1.req_ready = (state == IDLE) & gnt[1] & ~rst;

  assign op_ok    = alu_op_supported(alu_ctrl);
  assign consumed = (resp_vld[0] & p0.resp_ready) | (resp_vld[1] & p1.resp_ready);

  // The operand/ctrl registers double as the ALU drive, so outside ISSUE the
  // ALU keeps seeing the last issued op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
      resp_vld   <= 2'b00;
    end else begin
      case (state)
        // accept edge: latch the granted port's op
        IDLE: begin
          if (gnt != 2'b00) begin
            owner      <= gnt[1];
            last_grant <= gnt[1];
            alu_a      <= gnt[1] ? p1.req_a  : p0.req_a;
            alu_b      <= gnt[1] ? p1.req_b  : p0.req_b;
            alu_ctrl   <= gnt[1] ? p1.req_op : p0.req_op;
            state      <= ISSUE;
          end
        end
        // ALU samples the operands at the end of this cycle
        ISSUE: state <= CAPT;
        // ALU result is valid; the ALU's own zero flag is trusted only for SUB
        CAPT: begin
          if (!op_ok) begin
            res_q  <= '0;
            zero_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            res_q  <= alu_result;
            zero_q <= (alu_ctrl == ALU_SUB) ? alu_zero : (alu_result == '0);
            err_q  <= 1'b0;
          end
          resp_vld <= owner ? 2'b10 : 2'b01;
          state    <= RESP;
        end
        // hold the response until the owner consumes it
        RESP: begin
          if (consumed) begin
            resp_vld <= 2'b00;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign p0.resp_valid  = resp_vld[0];
  assign p0.resp_result = res_q;
  assign p0.resp_zero   = zero_q;
  assign p0.resp_err    = err_q;
  assign p1.resp_valid  = resp_vld[1];
  assign p1.resp_result = res_q;
  assign p1.resp_zero   = zero_q;
  assign p1.resp_err    = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural registered ALU.
// Define ALU_ARB_FIXED_PRIO_EN to exercise the fixed-priority build.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int XLEN = 32;
  localparam int OPW  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [XLEN-1:0] alu_a, alu_b;
  logic [OPW-1:0]  alu_ctrl;
  logic [XLEN-1:0] alu_result = '0;
  logic            alu_zero = 1'b0;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  alu_share_arbiter_if #(.XLEN(XLEN), .OPW(OPW)) bus0 ();
  alu_share_arbiter_if #(.XLEN(XLEN), .OPW(OPW)) bus1 ();

  alu_share_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
    .clk        (clk),
    .rst        (rst),
    .p0         (bus0.slave),
    .p1         (bus1.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  always #5 clk = ~clk;

  // Registered ALU; zero flag only updates on SUB, unknown codes return 0.
  always @(posedge clk) begin
    case (alu_ctrl)
      ALU_AND:  alu_result <= alu_a & alu_b;
      ALU_OR:   alu_result <= alu_a | alu_b;
      ALU_ADD:  alu_result <= alu_a + alu_b;
      ALU_XOR:  alu_result <= alu_a ^ alu_b;
      ALU_SLL:  alu_result <= alu_a << alu_b[4:0];
      ALU_SRL:  alu_result <= alu_a >> alu_b[4:0];
      ALU_SUB: begin
        alu_result <= alu_a - alu_b;
        alu_zero   <= (alu_a == alu_b);
      end
      ALU_ASR1: alu_result <= $unsigned($signed(alu_a) >>> 1);
      default:  alu_result <= '0;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic v, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [OPW-1:0] op);
    if (port == 0) begin
      bus0.req_valid = v; bus0.req_a = a; bus0.req_b = b; bus0.req_op = op;
    end else begin
      bus1.req_valid = v; bus1.req_a = a; bus1.req_b = b; bus1.req_op = op;
    end
  endtask

  task automatic wait_resp(input int port, output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ((port == 0 && bus0.resp_valid === 1'b1) || (port == 1 && bus1.resp_valid === 1'b1)) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic consume(input int port);
    if (port == 0) bus0.resp_ready = 1'b1; else bus1.resp_ready = 1'b1;
    tick();
    bus0.resp_ready = 1'b0;
    bus1.resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_req(0, 1'b1, 32'd1, 32'd2, ALU_ADD);
    tick(); tick();
    tot_cnt++; if (bus0.req_ready !== 1'b0) $display("FAIL reset_ready0: got %b want 0", bus0.req_ready); else pass_cnt++;
    tot_cnt++; if ({bus0.resp_valid, bus1.resp_valid} !== 2'b00) $display("FAIL reset_resp_valid: got %b want 00", {bus0.resp_valid, bus1.resp_valid}); else pass_cnt++;
    tot_cnt++; if ({bus0.resp_zero, bus0.resp_err} !== 2'b00) $display("FAIL reset_zero_err: got %b want 00", {bus0.resp_zero, bus0.resp_err}); else pass_cnt++;
    tot_cnt++; if (bus1.resp_result !== 32'h0) $display("FAIL reset_result: got %h want 0", bus1.resp_result); else pass_cnt++;
    tot_cnt++; if ({alu_a, alu_b, alu_ctrl} !== '0) $display("FAIL reset_alu_drive: got a=%h b=%h c=%h want 0", alu_a, alu_b, alu_ctrl); else pass_cnt++;
    set_req(0, 1'b0, '0, '0, '0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_op;
    set_req(0, 1'b1, 32'd5, 32'd7, ALU_ADD);
    #1;
    tot_cnt++; if (bus0.req_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", bus0.req_ready); else pass_cnt++;
    tick();
    tot_cnt++; if (bus0.req_ready !== 1'b0) $display("FAIL single_ready_drop: got %b want 0", bus0.req_ready); else pass_cnt++;
    tot_cnt++; if ({alu_a, alu_b, alu_ctrl} !== {32'd5, 32'd7, ALU_ADD}) $display("FAIL single_issue: got a=%0d b=%0d c=%h want 5 7 2", alu_a, alu_b, alu_ctrl); else pass_cnt++;
    set_req(0, 1'b0, '0, '0, '0);
    tick();
    tot_cnt++; if (bus0.resp_valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", bus0.resp_valid); else pass_cnt++;
    tick();
    tot_cnt++; if (bus0.resp_valid !== 1'b1) $display("FAIL single_latency: got %b want 1", bus0.resp_valid); else pass_cnt++;
    tot_cnt++; if ({bus0.resp_result, bus0.resp_zero, bus0.resp_err} !== {32'd12, 2'b00}) $display("FAIL single_data: got %0d z=%b e=%b want 12 0 0", bus0.resp_result, bus0.resp_zero, bus0.resp_err); else pass_cnt++;
    tot_cnt++; if (bus1.resp_valid !== 1'b0) $display("FAIL single_other_valid: got %b want 0", bus1.resp_valid); else pass_cnt++;
    consume(0);
    tot_cnt++; if (bus0.resp_valid !== 1'b0) $display("FAIL single_consume: got %b want 0", bus0.resp_valid); else pass_cnt++;
  endtask

  task automatic test_tie;
    bit got;
    rst = 1'b1; #3; rst = 1'b0;
    tick();
    set_req(0, 1'b1, 32'd9, 32'd9, ALU_SUB);
    set_req(1, 1'b1, 32'd0, 32'd0, ALU_OR);
    #1;
    tot_cnt++; if ({bus1.req_ready, bus0.req_ready} !== 2'b01) $display("FAIL tie1_grant: got %b want 01", {bus1.req_ready, bus0.req_ready}); else pass_cnt++;
    tick();
    set_req(0, 1'b0, '0, '0, '0);
    wait_resp(0, got);
    tot_cnt++; if (!got) $display("FAIL tie1_timeout: got no resp0_valid want 1"); else pass_cnt++;
    tot_cnt++; if ({bus0.resp_result, bus0.resp_zero, bus0.resp_err} !== {32'd0, 2'b10}) $display("FAIL tie1_data: got %0d z=%b e=%b want 0 1 0", bus0.resp_result, bus0.resp_zero, bus0.resp_err); else pass_cnt++;
    consume(0);
    set_req(0, 1'b1, 32'hF, 32'h3, ALU_AND);
    #1;
    tot_cnt++; if ({bus1.req_ready, bus0.req_ready} !== 2'b10) $display("FAIL tie2_grant: got %b want 10", {bus1.req_ready, bus0.req_ready}); else pass_cnt++;
    tick();
    set_req(1, 1'b0, '0, '0, '0);
    wait_resp(1, got);
    tot_cnt++; if (!got || bus0.resp_valid !== 1'b0) $display("FAIL tie2_steer: got v1=%b v0=%b want 1 0", bus1.resp_valid, bus0.resp_valid); else pass_cnt++;
    tot_cnt++; if ({bus1.resp_result, bus1.resp_zero, bus1.resp_err} !== {32'd0, 2'b10}) $display("FAIL tie2_data: got %0d z=%b e=%b want 0 1 0", bus1.resp_result, bus1.resp_zero, bus1.resp_err); else pass_cnt++;
    consume(1);
    set_req(1, 1'b1, 32'd1, 32'd1, ALU_ADD);
    #1;
    tot_cnt++; if ({bus1.req_ready, bus0.req_ready} !== 2'b01) $display("FAIL tie3_grant: got %b want 01", {bus1.req_ready, bus0.req_ready}); else pass_cnt++;
    tick();
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    wait_resp(0, got);
    tot_cnt++; if (!got || bus0.resp_result !== 32'd3) $display("FAIL tie3_data: got v=%b r=%0d want 1 3", got, bus0.resp_result); else pass_cnt++;
    consume(0);
  endtask

  task automatic test_fixed_prio;
    bit got;
    set_req(0, 1'b1, 32'd4, 32'd1, ALU_SLL);
    set_req(1, 1'b1, 32'd4, 32'd1, ALU_SRL);
    for (int k = 0; k < 3; k++) begin
      #1;
      tot_cnt++; if ({bus1.req_ready, bus0.req_ready} !== 2'b01) $display("FAIL fixed_grant%0d: got %b want 01", k, {bus1.req_ready, bus0.req_ready}); else pass_cnt++;
      wait_resp(0, got);
      tot_cnt++; if (!got || bus0.resp_result !== 32'd8 || bus1.resp_valid !== 1'b0) $display("FAIL fixed_resp%0d: got v=%b r=%0d v1=%b want 1 8 0", k, got, bus0.resp_result, bus1.resp_valid); else pass_cnt++;
      consume(0);
    end
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
  endtask

  task automatic test_backpressure;
    bit got;
    bit stable;
    set_req(1, 1'b1, 32'd100, 32'd23, ALU_ADD);
    tick();
    set_req(1, 1'b0, '0, '0, '0);
    set_req(0, 1'b1, 32'd2, 32'd3, ALU_ADD);
    wait_resp(1, got);
    tot_cnt++; if (!got) $display("FAIL bp_timeout: got no resp1_valid want 1"); else pass_cnt++;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus1.resp_valid !== 1'b1 || bus1.resp_result !== 32'd123 || bus0.req_ready !== 1'b0) stable = 1'b0;
      tick();
    end
    tot_cnt++; if (!stable) $display("FAIL bp_hold: got v1=%b r=%0d rdy0=%b want 1 123 0", bus1.resp_valid, bus1.resp_result, bus0.req_ready); else pass_cnt++;
    consume(1);
    tot_cnt++; if (bus0.req_ready !== 1'b1) $display("FAIL bp_grant_after: got %b want 1", bus0.req_ready); else pass_cnt++;
    tick();
    set_req(0, 1'b0, '0, '0, '0);
    wait_resp(0, got);
    tot_cnt++; if (!got || bus0.resp_result !== 32'd5) $display("FAIL bp_req0_data: got v=%b r=%0d want 1 5", got, bus0.resp_result); else pass_cnt++;
    consume(0);
  endtask

  task automatic test_zero_flag;
    bit got;
    set_req(0, 1'b1, 32'd5, 32'd3, ALU_SUB);
    tick();
    set_req(0, 1'b0, '0, '0, '0);
    wait_resp(0, got);
    tot_cnt++; if (!got || {bus0.resp_result, bus0.resp_zero} !== {32'd2, 1'b0}) $display("FAIL sub_nonzero: got r=%0d z=%b want 2 0", bus0.resp_result, bus0.resp_zero); else pass_cnt++;
    consume(0);
    set_req(0, 1'b1, 32'hF0, 32'h0F, ALU_AND);
    tick();
    set_req(0, 1'b0, '0, '0, '0);
    wait_resp(0, got);
    tot_cnt++; if (!got || {bus0.resp_result, bus0.resp_zero} !== {32'd0, 1'b1}) $display("FAIL and_local_zero: got r=%0d z=%b want 0 1", bus0.resp_result, bus0.resp_zero); else pass_cnt++;
    consume(0);
    set_req(0, 1'b1, 32'h8000_0004, 32'd0, ALU_ASR1);
    tick();
    set_req(0, 1'b0, '0, '0, '0);
    wait_resp(0, got);
    tot_cnt++; if (!got || {bus0.resp_result, bus0.resp_zero, bus0.resp_err} !== {32'hC000_0002, 2'b00}) $display("FAIL asr1: got r=%h z=%b e=%b want c0000002 0 0", bus0.resp_result, bus0.resp_zero, bus0.resp_err); else pass_cnt++;
    consume(0);
  endtask

  task automatic test_illegal_op;
    bit got;
    set_req(1, 1'b1, 32'hFFFF, 32'd1, 4'b1010);
    tick();
    set_req(1, 1'b0, '0, '0, '0);
    wait_resp(1, got);
    tot_cnt++; if (!got || {bus1.resp_result, bus1.resp_err, bus1.resp_zero} !== {32'd0, 2'b11}) $display("FAIL illegal_op: got v=%b r=%0d e=%b z=%b want 1 0 1 1", got, bus1.resp_result, bus1.resp_err, bus1.resp_zero); else pass_cnt++;
    consume(1);
  endtask

  task automatic test_reset_mid;
    bit got;
    bit leaked;
    set_req(0, 1'b1, 32'd1, 32'd1, ALU_ADD);
    tick();
    set_req(0, 1'b0, '0, '0, '0);
    tick();
    rst = 1'b1; #2; rst = 1'b0;
    tot_cnt++; if ({alu_a, alu_ctrl} !== '0) $display("FAIL rstmid_alu: got a=%h c=%h want 0", alu_a, alu_ctrl); else pass_cnt++;
    leaked = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus0.resp_valid !== 1'b0 || bus1.resp_valid !== 1'b0) leaked = 1'b1;
    end
    tot_cnt++; if (leaked) $display("FAIL rstmid_leak: got a response want none"); else pass_cnt++;
    set_req(0, 1'b1, 32'hF0F0, 32'h0FF0, ALU_XOR);
    tick();
    set_req(0, 1'b0, '0, '0, '0);
    wait_resp(0, got);
    tot_cnt++; if (!got || bus0.resp_result !== 32'hFF00) $display("FAIL rstmid_xor: got v=%b r=%h want 1 ff00", got, bus0.resp_result); else pass_cnt++;
    consume(0);
  endtask

  initial begin
    bus0.req_valid = 1'b0; bus0.req_a = '0; bus0.req_b = '0; bus0.req_op = '0; bus0.resp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_a = '0; bus1.req_b = '0; bus1.req_op = '0; bus1.resp_ready = 1'b0;
    test_reset();
    test_single_op();
`ifdef ALU_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_tie();
`endif
    test_backpressure();
    test_zero_flag();
    test_illegal_op();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
